// File: rtl/nugget_pkg.sv
// Shared types and constants for the drag-and-collect object.
package nugget_pkg;

  localparam int unsigned SCORE_W = 8;
  localparam int unsigned COORD_W = 11;

  typedef logic signed [COORD_W-1:0] coord_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ATTACHED,
    ST_COLLECTED,
    ST_RESPAWN,
    ST_GONE
  } state_t;

endpackage

// File: rtl/nugget_respawn_timer.sv
// Frame counter for the hidden interval after collection; done fires on the
// startOfFrame that completes `limit` frames since the last start pulse.
module nugget_respawn_timer (
  input  logic       clk,
  input  logic       resetN,
  input  logic       start,
  input  logic       startOfFrame,
  input  logic [7:0] limit,
  output logic       done
);

  logic [7:0] r_count;
  logic       w_last;

  assign w_last = (r_count == (limit - 8'd1));
  assign done   = startOfFrame && !start && w_last;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (start) begin
      r_count <= '0;
    end else if (startOfFrame) begin
      r_count <= r_count + 8'd1;
    end
  end

endmodule

// File: rtl/nugget_drag_move.sv
// Grabbable object: rests at its home position, follows the cable once hooked,
// scores on reel-in. Define NUGGET_RESPAWN_EN to reappear after RESPAWN_FRAMES.
module nugget_drag_move
  import nugget_pkg::*;
#(
  parameter coord_t              INITIAL_X      = 11'sd400,
  parameter coord_t              INITIAL_Y      = 11'sd300,
  parameter coord_t              OFFSET_X       = 11'sd0,
  parameter coord_t              OFFSET_Y       = 11'sd16,
  parameter logic [SCORE_W-1:0]  OBJECT_VALUE   = 8'd50,
  parameter int                  RESPAWN_FRAMES = 60
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               collision,
  input  coord_t             cableTopLeftX,
  input  coord_t             cableTopLeftY,
  input  logic               IsInCircular,
  output coord_t             topLeftX,
  output coord_t             topLeftY,
  output logic               visible,
  output logic               grabbed,
  output logic               scorePulse,
  output logic [SCORE_W-1:0] scoreValue
);

  if (RESPAWN_FRAMES < 1 || RESPAWN_FRAMES > 255) begin : g_bad_respawn_frames
    $error("nugget_drag_move: RESPAWN_FRAMES must be within 1..255");
  end

  state_t             r_state;
  coord_t             r_x;
  coord_t             r_y;
  logic               r_visible;
  logic               r_grabbed;
  logic               r_pulse;
  logic [SCORE_W-1:0] r_value;
  logic               w_respawn_done;

`ifdef NUGGET_RESPAWN_EN
  localparam logic [7:0] RESPAWN_LIMIT = 8'(RESPAWN_FRAMES);
  logic w_respawn_start;

  // The counter is cleared during the single COLLECTED cycle.
  assign w_respawn_start = (r_state == ST_COLLECTED);

  nugget_respawn_timer u_respawn_timer (
    .clk          (clk),
    .resetN       (resetN),
    .start        (w_respawn_start),
    .startOfFrame (startOfFrame),
    .limit        (RESPAWN_LIMIT),
    .done         (w_respawn_done)
  );
`else
  assign w_respawn_done = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state   <= ST_IDLE;
      r_x       <= INITIAL_X;
      r_y       <= INITIAL_Y;
      r_visible <= 1'b1;
      r_grabbed <= 1'b0;
      r_pulse   <= 1'b0;
      r_value   <= '0;
    end else begin
      r_pulse <= 1'b0;
      r_value <= '0;
      case (r_state)
        ST_IDLE: begin
          r_x       <= INITIAL_X;
          r_y       <= INITIAL_Y;
          r_visible <= 1'b1;
          r_grabbed <= 1'b0;
          if (collision && !IsInCircular) begin
            r_state   <= ST_ATTACHED;
            r_grabbed <= 1'b1;
          end
        end
        ST_ATTACHED: begin
          // Reel-in wins over a coincident frame update.
          if (IsInCircular) begin
            r_state   <= ST_COLLECTED;
            r_visible <= 1'b0;
            r_grabbed <= 1'b0;
            r_pulse   <= 1'b1;
            r_value   <= OBJECT_VALUE;
          end else if (startOfFrame) begin
            r_x <= cableTopLeftX + OFFSET_X;
            r_y <= cableTopLeftY + OFFSET_Y;
          end
        end
        ST_COLLECTED: begin
`ifdef NUGGET_RESPAWN_EN
          r_state <= ST_RESPAWN;
`else
          r_state <= ST_GONE;
`endif
        end
        ST_RESPAWN: begin
          if (w_respawn_done) begin
            r_state   <= ST_IDLE;
            r_x       <= INITIAL_X;
            r_y       <= INITIAL_Y;
            r_visible <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_GONE;
          r_visible <= 1'b0;
          r_grabbed <= 1'b0;
        end
      endcase
    end
  end

  assign topLeftX   = r_x;
  assign topLeftY   = r_y;
  assign visible    = r_visible;
  assign grabbed    = r_grabbed;
  assign scorePulse = r_pulse;
  assign scoreValue = r_value;

endmodule

// File: tb/tb_nugget_drag_move.sv
// Directed bench for nugget_drag_move: vector table plus hand-written
// respawn/gone, coordinate-wrap and mid-drag reset sequences.
module tb_nugget_drag_move;

  logic               clk = 1'b0;
  logic               resetN;
  logic               startOfFrame;
  logic               collision;
  logic               IsInCircular;
  logic signed [10:0] cableTopLeftX;
  logic signed [10:0] cableTopLeftY;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               visible;
  logic               grabbed;
  logic               scorePulse;
  logic [7:0]         scoreValue;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nugget_drag_move #(
    .INITIAL_X      (11'sd400),
    .INITIAL_Y      (11'sd300),
    .OFFSET_X       (11'sd0),
    .OFFSET_Y       (11'sd16),
    .OBJECT_VALUE   (8'd50),
    .RESPAWN_FRAMES (3)
  ) dut (
    .clk           (clk),
    .resetN        (resetN),
    .startOfFrame  (startOfFrame),
    .collision     (collision),
    .cableTopLeftX (cableTopLeftX),
    .cableTopLeftY (cableTopLeftY),
    .IsInCircular  (IsInCircular),
    .topLeftX      (topLeftX),
    .topLeftY      (topLeftY),
    .visible       (visible),
    .grabbed       (grabbed),
    .scorePulse    (scorePulse),
    .scoreValue    (scoreValue)
  );

  typedef struct {
    logic col;
    logic isc;
    logic sof;
    int   cx;
    int   cy;
    int   ex;
    int   ey;
    logic evis;
    logic egrab;
    logic epulse;
    int   eval;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic col, input logic isc, input logic sof,
                              input int cx, input int cy, input int ex, input int ey,
                              input logic evis, input logic egrab, input logic epulse,
                              input int eval);
    vec_t v;
    v.col = col; v.isc = isc; v.sof = sof; v.cx = cx; v.cy = cy;
    v.ex = ex; v.ey = ey; v.evis = evis; v.egrab = egrab; v.epulse = epulse; v.eval = eval;
    return v;
  endfunction

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_pos(input string tag, input int ex, input int ey);
    check({tag, ".x"}, 32'(topLeftX), ex);
    check({tag, ".y"}, 32'(topLeftY), ey);
  endtask

  task automatic check_flags(input string tag, input logic evis, input logic egrab,
                             input logic epulse, input int eval);
    check({tag, ".visible"}, {31'd0, visible}, {31'd0, evis});
    check({tag, ".grabbed"}, {31'd0, grabbed}, {31'd0, egrab});
    check({tag, ".scorePulse"}, {31'd0, scorePulse}, {31'd0, epulse});
    check({tag, ".scoreValue"}, {24'd0, scoreValue}, eval);
  endtask

  task automatic step(input logic col, input logic isc, input logic sof,
                      input int cx, input int cy);
    collision     = col;
    IsInCircular  = isc;
    startOfFrame  = sof;
    cableTopLeftX = 11'(cx);
    cableTopLeftY = 11'(cy);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(0, 0, 0,    0,    0,  400,  300, 1, 0, 0,  0);
    vecs[1]  = mk(0, 0, 1,    0,    0,  400,  300, 1, 0, 0,  0);
    vecs[2]  = mk(0, 0, 1,    0,    0,  400,  300, 1, 0, 0,  0);
    vecs[3]  = mk(0, 0, 1,    0,    0,  400,  300, 1, 0, 0,  0);
    vecs[4]  = mk(1, 1, 0,    0,    0,  400,  300, 1, 0, 0,  0);
    vecs[5]  = mk(1, 0, 0,    0,    0,  400,  300, 1, 1, 0,  0);
    vecs[6]  = mk(0, 0, 0,  300,  200,  400,  300, 1, 1, 0,  0);
    vecs[7]  = mk(0, 0, 1,  300,  200,  300,  216, 1, 1, 0,  0);
    vecs[8]  = mk(1, 0, 0,  100,  100,  300,  216, 1, 1, 0,  0);
    vecs[9]  = mk(0, 0, 1,  -20,  -30,  -20,  -14, 1, 1, 0,  0);
    vecs[10] = mk(0, 1, 1,    0,    0,  -20,  -14, 0, 0, 1, 50);
    vecs[11] = mk(0, 0, 0,    0,    0,  -20,  -14, 0, 0, 0,  0);

    resetN        = 1'b0;
    startOfFrame  = 1'b0;
    collision     = 1'b0;
    IsInCircular  = 1'b0;
    cableTopLeftX = '0;
    cableTopLeftY = '0;
    #12;
    check_pos("reset", 400, 300);
    check_flags("reset", 1, 0, 0, 0);
    resetN = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].col, vecs[i].isc, vecs[i].sof, vecs[i].cx, vecs[i].cy);
      check_pos($sformatf("vec%0d", i), vecs[i].ex, vecs[i].ey);
      check_flags($sformatf("vec%0d", i), vecs[i].evis, vecs[i].egrab,
                  vecs[i].epulse, vecs[i].eval);
    end

`ifdef NUGGET_RESPAWN_EN
    for (int f = 1; f <= 3; f++) begin
      step(0, 0, 1, 0, 0);
      check_flags($sformatf("respawn_f%0d", f), (f == 3), 0, 0, 0);
      if (f == 3) check_pos("respawn_home", 400, 300);
    end
    step(1, 0, 0, 0, 0);
    check_flags("regrab", 1, 1, 0, 0);
`else
    for (int f = 1; f <= 10; f++) begin
      step(1, 0, 1, 50, 60);
      check_flags($sformatf("gone_f%0d", f), 0, 0, 0, 0);
    end
`endif

    // Coordinate wrap, then reset in the middle of a drag.
    #3 resetN = 1'b0;
    #2 resetN = 1'b1;
    step(1, 0, 0, 0, 0);
    check_flags("wrap_attach", 1, 1, 0, 0);
    step(0, 0, 1, 1020, 1020);
    check_pos("wrap", 1020, -1012);
    step(0, 0, 1, -20, -30);
    check_pos("neg", -20, -14);
    IsInCircular = 1'b1;
    #3 resetN = 1'b0;
    #1;
    check_pos("middrag_rst", 400, 300);
    check_flags("middrag_rst", 1, 0, 0, 0);
    #2 resetN = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step(0, 1, 1, -20, -30);
      check_pos($sformatf("post_rst%0d", c), 400, 300);
      check_flags($sformatf("post_rst%0d", c), 1, 0, 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nugget_drag_move.md
NUGGET_DRAG_MOVE -- requirements
Module: nugget_drag_move

Interface
REQ-001 Parameter INITIAL_X, default 11'sd400, resting top-left X of the object.
REQ-002 Parameter INITIAL_Y, default 11'sd300, resting top-left Y of the object.
REQ-003 Parameter OFFSET_X, default 11'sd0, X offset from the cable top-left while attached.
REQ-004 Parameter OFFSET_Y, default 11'sd16, Y offset from the cable top-left while attached.
REQ-005 Parameter OBJECT_VALUE, default 8'd50, score reported on collection.
REQ-006 Parameter RESPAWN_FRAMES, default 60, frames hidden before reappearing; legal range 1..255.
REQ-007 Port clk, input, 1, system clock; all state changes on its rising edge.
REQ-008 Port resetN, input, 1, asynchronous active-low reset.
REQ-009 Port startOfFrame, input, 1, one-cycle pulse per video frame.
REQ-010 Port collision, input, 1, cable tip overlaps this object's drawing request.
REQ-011 Port cableTopLeftX, input, 11 signed, current cable top-left X.
REQ-012 Port cableTopLeftY, input, 11 signed, current cable top-left Y.
REQ-013 Port IsInCircular, input, 1, cable has returned to and is in swing mode.
REQ-014 Port topLeftX, output, 11 signed, object top-left X.
REQ-015 Port topLeftY, output, 11 signed, object top-left Y.
REQ-016 Port visible, output, 1, enables the object's drawing request.
REQ-017 Port grabbed, output, 1, object is attached to the cable.
REQ-018 Port scorePulse, output, 1, one-cycle pulse on collection.
REQ-019 Port scoreValue, output, 8, equals OBJECT_VALUE while scorePulse=1, else 0.

Function
REQ-020 The FSM SHALL have states IDLE, ATTACHED, COLLECTED, RESPAWN and GONE.
REQ-021 IDLE: visible=1, grabbed=0, position held at INITIAL_X/INITIAL_Y.
REQ-022 IDLE->ATTACHED SHALL occur on the edge where collision=1 and IsInCircular=0; grabbed=1 from the next cycle.
REQ-023 A collision with IsInCircular=1 SHALL be ignored.
REQ-024 Collision SHALL be ignored in every state other than IDLE.
REQ-025 ATTACHED: on each startOfFrame, topLeftX<=cableTopLeftX+OFFSET_X and topLeftY<=cableTopLeftY+OFFSET_Y, truncated to 11 bits (two's-complement wrap); otherwise position held.
REQ-026 ATTACHED->COLLECTED SHALL occur on the edge where IsInCircular=1; if startOfFrame is also 1 that cycle, there is no position update.
REQ-027 COLLECTED SHALL last exactly one cycle, with scorePulse=1, scoreValue=OBJECT_VALUE, visible=0 and grabbed=0.
REQ-028 RESPAWN: visible=0 and an 8-bit frame counter cleared on entry increments per startOfFrame.
REQ-029 On the startOfFrame where the counter equals RESPAWN_FRAMES-1, the FSM SHALL go to IDLE and reload INITIAL_X/INITIAL_Y in the same edge.
REQ-030 GONE SHALL be absorbing until reset, with visible=0, grabbed=0 and scorePulse=0.

Reset
REQ-031 resetN=0 SHALL asynchronously force state IDLE, topLeftX=INITIAL_X, topLeftY=INITIAL_Y, visible=1, grabbed=0, scorePulse=0, scoreValue=0 and counter=0.
REQ-032 Reset asserted in any state, including ATTACHED mid-drag, SHALL abort that operation without emitting scorePulse.

Configuration
REQ-033 With NUGGET_RESPAWN_EN defined, COLLECTED SHALL go to RESPAWN.
REQ-034 Without NUGGET_RESPAWN_EN, COLLECTED SHALL go to GONE and the RESPAWN counter logic SHALL be absent.

Structure
REQ-035 Package nugget_pkg SHALL hold the state enum type, SCORE_W=8 and the signed coordinate typedef (11-bit).
REQ-036 The frame counter SHALL be a sub-module, nugget_respawn_timer (inputs: start, startOfFrame, limit; output: done pulse), instantiated only under NUGGET_RESPAWN_EN.

Verification
REQ-037 Reset, then 3 frames with no stimulus -> topLeft=(400,300), visible=1, grabbed=0, scorePulse never asserted.
REQ-038 IsInCircular=0, collision pulse, then startOfFrame with cable=(300,200) -> grabbed=1 next cycle and topLeft=(300,216) after the frame edge.
REQ-039 Collision with IsInCircular=1 -> state stays IDLE and grabbed stays 0.
REQ-040 While attached, IsInCircular rises together with startOfFrame -> position unchanged, then one-cycle scorePulse with scoreValue=50, then visible=0.
REQ-041 With NUGGET_RESPAWN_EN defined and RESPAWN_FRAMES=3 -> visible returns to 1 on the 3rd startOfFrame after COLLECTED, with topLeft=(400,300); without the macro, visible stays 0 for 10 frames.
REQ-042 Cable at (-20,-30) while attached -> topLeft=(-20,-14); resetN pulsed low mid-drag -> immediate return to (400,300) with no scorePulse.
